regfile_wb_scheduler: RTL and testbench
=======================================

# regfile_wb_scheduler

Writeback scheduler and scoreboard for the RV32I core's 32-entry register file, which has one write port and registered (one-cycle) reads. It arbitrates the ALU and load/store unit (LSU) writeback streams onto the single write port using valid/ready handshakes. It tracks registers with an outstanding load and reports read hazards to the issue stage. It drives the register file's `rd_we`/`rd_addr`/`rd_data` inputs directly from flops.

## Interface
- `DATA_WIDTH`, 32, width of writeback data
- `clk` input 1: single clock, all state updates on rising edge
- `rst` input 1: synchronous, active-high reset
- `alu_valid` input 1: ALU has a result
- `alu_rd` input 5: ALU destination register
- `alu_data` input DATA_WIDTH: ALU result
- `alu_ready` output 1: ALU result accepted this cycle
- `lsu_valid` input 1: load data available
- `lsu_rd` input 5: load destination register
- `lsu_data` input DATA_WIDTH: load data
- `lsu_ready` output 1: load data accepted this cycle
- `issue_valid` input 1: issue stage dispatching a load
- `issue_rd` input 5: destination of the dispatched load
- `issue_ready` output 1: load dispatch accepted
- `rs1_addr`, `rs2_addr` input 5 each: source registers of the instruction in decode
- `rs1_busy`, `rs2_busy` output 1 each: source not yet readable, so decode must stall
- `rd_we` output 1: register file write enable, registered
- `rd_addr` output 5: register file write address, registered
- `rd_data` output DATA_WIDTH: register file write data, registered

## Operation
- **State**
  - `sb[31:0]` is the pending-load scoreboard.
  - `last_lsu` is 1 when the most recent grant went to the LSU.
  - The output write flops hold `rd_we`, `rd_addr` and `rd_data`.
- **Eligibility**
  - LSU is eligible when `lsu_valid`.
  - ALU is eligible when `alu_valid` and not (`alu_rd`≠0 and `sb[alu_rd]`).
  - This blocks WAW hazards: an ALU write never overtakes an older load to the same register.
- **Arbitration** (combinational, from current inputs and `last_lsu`)
  - If only one source is eligible, it is granted.
  - If both are eligible, the source not granted last is granted (round-robin).
  - If neither is eligible, there is no grant.
  - `alu_ready`/`lsu_ready` equal that source's grant. At most one is high per cycle.
- **Handshake** (valid & ready)
  - Next cycle: `rd_we`=1 and `rd_addr`/`rd_data` take the granted values.
  - `last_lsu` updates to the granted source.
  - If the granted rd=0, the request is accepted, `rd_we`=0 next cycle, and `last_lsu` still updates.
- **No handshake:** `rd_we`=0 next cycle; `rd_addr`/`rd_data` hold their values.
- **Scoreboard**
  - `issue_ready` = (`issue_rd`==0) or !`sb[issue_rd]`, evaluated on current `sb`.
  - On an issue handshake with `issue_rd`≠0, `sb[issue_rd]` is set.
  - On an LSU handshake, `sb[lsu_rd]` is cleared.
  - If set and clear hit the same index in one cycle, the set wins. This only happens when `issue_rd` was free at evaluation, so it marks a new load.
  - `sb[0]` is always 0.
- **Hazard outputs**
  - `rsN_busy` = `rsN_addr`≠0 and (`sb[rsN_addr]` or (`rd_we` and `rd_addr`==`rsN_addr`)).
  - This covers the cycle where the write flop is committing: the register file's registered read would still return the old value.
- **Reset**
  - `sb`=0, `last_lsu`=1 (so ALU wins the first tie).
  - `rd_we`=0, `rd_addr`=0, `rd_data`=0.
  - All in-flight scoreboard entries are discarded. An accepted but uncommitted write is dropped: the write flops clear.

## Timing
- **Request to register file write:** 1 cycle from handshake to `rd_we` high; the register file captures data on the following edge.
- **Earliest clean read after a write:** the decode cycle after `rd_we` deasserts for that address. `rsN_busy` enforces this.
- **Combinational paths**
  - `alu_ready`, `lsu_ready` and `issue_ready` are functions of same-cycle inputs and state.
  - `rsN_busy` depends on state and the `rsN_addr` inputs only.
- **Throughput:** one writeback per cycle sustained. Under continuous contention each source gets every other cycle.
- **Requester obligations:** a requester holding valid must keep rd and data stable until ready. The scheduler never drops a non-x0 accepted write except on `rst`.

## Test plan
- **Reset:** assert `rst` 2 cycles with all valids high → `rd_we`=0, `rd_addr`=0, `rd_data`=0, all readies low during reset; first post-reset tie grants ALU.
- **Contention:** ALU (rd=5, 0x11) and LSU (rd=6, 0x22) both valid for 4 cycles with new data each cycle → grants alternate ALU, LSU, ALU, LSU; `rd_we` high on 4 consecutive cycles with matching addr/data, one cycle after each grant.
- **WAW block:** issue load rd=7 (`sb[7]`=1), then ALU valid rd=7 → `alu_ready`=0 until LSU writes rd=7. The LSU write commits first; ALU is granted the cycle after the LSU handshake.
- **Hazard:** after load issue rd=3, `rs1_addr`=3 → `rs1_busy`=1 until LSU handshake; busy stays 1 in the `rd_we` cycle, then 0. `rs2_addr`=0 → `rs2_busy`=0 always.
- **x0 handling:** ALU rd=0 data 0xDEADBEEF → `alu_ready`=1, `rd_we`=0 next cycle; issue load rd=0 → `issue_ready`=1, `sb` unchanged.
- **Re-issue and reset mid-flight:**
  - Same-cycle LSU clear of rd=9 plus issue rd=9 → `issue_ready`=0 that cycle, accepted next cycle, `sb[9]`=1.
  - `rst` with `sb`≠0 → `sb`=0 and all busy outputs low next cycle.

Source files
------------

// File: rtl/regfile_wb_scheduler_if.sv
// Writeback scheduler bus: ALU/LSU writeback handshakes, load dispatch,
// decode hazard query and the register file write port.
interface regfile_wb_scheduler_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  alu_valid;
  logic [4:0]            alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  alu_ready;

  logic                  lsu_valid;
  logic [4:0]            lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;
  logic                  lsu_ready;

  logic                  issue_valid;
  logic [4:0]            issue_rd;
  logic                  issue_ready;

  logic [4:0]            rs1_addr;
  logic [4:0]            rs2_addr;
  logic                  rs1_busy;
  logic                  rs2_busy;

  logic                  rd_we;
  logic [4:0]            rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  // Pipeline side: drives requests, sees readies, hazards and the write port.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output issue_valid, issue_rd,
    output rs1_addr, rs2_addr,
    input  alu_ready, lsu_ready, issue_ready,
    input  rs1_busy, rs2_busy,
    input  rd_we, rd_addr, rd_data
  );

  // Scheduler side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  issue_valid, issue_rd,
    input  rs1_addr, rs2_addr,
    output alu_ready, lsu_ready, issue_ready,
    output rs1_busy, rs2_busy,
    output rd_we, rd_addr, rd_data
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for the 32-entry, single-write-port register file.
// Round-robin arbitrates ALU and LSU results onto registered write flops,
// keeps a pending-load scoreboard and reports source-operand hazards.
module regfile_wb_scheduler #(
  parameter int DATA_WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst,
  regfile_wb_scheduler_if.slave bus
);

  logic [31:0]           sb;
  logic [31:0]           sb_next;
  logic                  last_lsu;
  logic                  wb_we;
  logic [4:0]            wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;

  logic alu_elig;
  logic lsu_elig;
  logic grant_alu;
  logic grant_lsu;
  logic issue_ok;
  logic issue_hs;

  // Eligibility and round-robin grant; ALU is held off while an older load
  // to the same register is outstanding so it cannot overtake it.
  always_comb begin
    alu_elig  = bus.alu_valid && !((bus.alu_rd != 5'd0) && sb[bus.alu_rd]);
    lsu_elig  = bus.lsu_valid;
    grant_alu = !rst && alu_elig && (!lsu_elig || last_lsu);
    grant_lsu = !rst && lsu_elig && (!alu_elig || !last_lsu);
  end

  // Load dispatch is accepted only when its destination has no pending load.
  always_comb begin
    issue_ok = !rst && ((bus.issue_rd == 5'd0) || !sb[bus.issue_rd]);
    issue_hs = bus.issue_valid && issue_ok;
  end

  // Scoreboard next state: LSU completion clears, new dispatch sets (set wins).
  always_comb begin
    sb_next = sb;
    if (grant_lsu)
      sb_next[bus.lsu_rd] = 1'b0;
    if (issue_hs && (bus.issue_rd != 5'd0))
      sb_next[bus.issue_rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  // Hazards include the commit cycle, since the registered read still sees old data.
  always_comb begin
    bus.rs1_busy = (bus.rs1_addr != 5'd0) &&
                   (sb[bus.rs1_addr] || (wb_we && (wb_addr == bus.rs1_addr)));
    bus.rs2_busy = (bus.rs2_addr != 5'd0) &&
                   (sb[bus.rs2_addr] || (wb_we && (wb_addr == bus.rs2_addr)));
  end

  assign bus.alu_ready   = grant_alu;
  assign bus.lsu_ready   = grant_lsu;
  assign bus.issue_ready = issue_ok;
  assign bus.rd_we       = wb_we;
  assign bus.rd_addr     = wb_addr;
  assign bus.rd_data     = wb_data;

  // Scoreboard and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb       <= '0;
      last_lsu <= 1'b1;
    end else begin
      sb <= sb_next;
      if (grant_alu)
        last_lsu <= 1'b0;
      else if (grant_lsu)
        last_lsu <= 1'b1;
    end
  end

  // Write-port flops; x0 writes are accepted but never reach the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (grant_alu) begin
      wb_we <= (bus.alu_rd != 5'd0);
      if (bus.alu_rd != 5'd0) begin
        wb_addr <= bus.alu_rd;
        wb_data <= bus.alu_data;
      end
    end else if (grant_lsu) begin
      wb_we <= (bus.lsu_rd != 5'd0);
      if (bus.lsu_rd != 5'd0) begin
        wb_addr <= bus.lsu_rd;
        wb_data <= bus.lsu_data;
      end
    end else begin
      wb_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: scenario tasks predict grants and push
// expected register file writes; a monitor pops them as rd_we commits.
module tb_regfile_wb_scheduler;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    int          due;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];

  regfile_wb_scheduler_if #(.DATA_WIDTH(32)) bus();

  regfile_wb_scheduler #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every committed write must match the oldest expectation.
  initial begin
    wb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.rd_we === 1'b1) begin
        tests++;
        if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
          fails++;
          $display("FAIL wb_unexpected: got write addr=%0d data=%h at cycle %0d, required no write",
                   bus.rd_addr, bus.rd_data, cyc);
        end else begin
          e = exp_q.pop_front();
          if (bus.rd_addr !== e.addr || bus.rd_data !== e.data) begin
            fails++;
            $display("FAIL wb_data: got addr=%0d data=%h, required addr=%0d data=%h",
                     bus.rd_addr, bus.rd_data, e.addr, e.data);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        tests++;
        fails++;
        e = exp_q.pop_front();
        $display("FAIL wb_missing: got rd_we=%b, required write addr=%0d data=%h",
                 bus.rd_we, e.addr, e.data);
      end
    end
  end

  task automatic push_wb(input logic [4:0] addr, input logic [31:0] data);
    wb_t e;
    e.due  = cyc + 1;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.lsu_valid   = 1'b0;
    bus.lsu_rd      = '0;
    bus.lsu_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'hA1;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd2; bus.lsu_data = 32'hB2;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
    bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if ({bus.alu_ready, bus.lsu_ready, bus.issue_ready} !== 3'b000) begin
        fails++;
        $display("FAIL reset_ready: got alu/lsu/issue=%b%b%b, required 000",
                 bus.alu_ready, bus.lsu_ready, bus.issue_ready);
      end
      tick();
      tests++;
      if (bus.rd_we !== 1'b0 || bus.rd_addr !== 5'd0 || bus.rd_data !== 32'h0) begin
        fails++;
        $display("FAIL reset_wb: got we=%b addr=%0d data=%h, required 0/0/0",
                 bus.rd_we, bus.rd_addr, bus.rd_data);
      end
    end
    rst = 1'b0;
    bus.issue_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_tie: got alu=%b lsu=%b, required alu=1 lsu=0",
               bus.alu_ready, bus.lsu_ready);
    end
    push_wb(5'd1, 32'hA1);
    tick();
    bus.alu_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.lsu_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_lsu_alone: got lsu_ready=%b, required 1", bus.lsu_ready);
    end
    push_wb(5'd2, 32'hB2);
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_contention();
    for (int i = 0; i < 4; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h11 + i;
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd6; bus.lsu_data = 32'h22 + i;
      @(negedge clk);
      tests++;
      if (bus.alu_ready !== (i % 2 == 0) || bus.lsu_ready !== (i % 2 == 1)) begin
        fails++;
        $display("FAIL contention_grant%0d: got alu=%b lsu=%b, required alu=%b lsu=%b",
                 i, bus.alu_ready, bus.lsu_ready, (i % 2 == 0), (i % 2 == 1));
      end
      if (i % 2 == 0) push_wb(5'd5, 32'h11 + i);
      else            push_wb(5'd6, 32'h22 + i);
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_waw_block();
    bus.rs1_addr = 5'd7;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    @(negedge clk);
    tests++;
    if (bus.issue_ready !== 1'b1) begin
      fails++;
      $display("FAIL waw_issue: got issue_ready=%b, required 1", bus.issue_ready);
    end
    tick();
    bus.issue_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (bus.alu_ready !== 1'b0 || bus.rs1_busy !== 1'b1) begin
        fails++;
        $display("FAIL waw_blocked%0d: got alu_ready=%b rs1_busy=%b, required 0/1",
                 i, bus.alu_ready, bus.rs1_busy);
      end
      tick();
    end
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h70;
    @(negedge clk);
    tests++;
    if (bus.lsu_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
      fails++;
      $display("FAIL waw_lsu_first: got lsu=%b alu=%b, required lsu=1 alu=0",
               bus.lsu_ready, bus.alu_ready);
    end
    push_wb(5'd7, 32'h70);
    tick();
    bus.lsu_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.alu_ready !== 1'b1) begin
      fails++;
      $display("FAIL waw_alu_after: got alu_ready=%b, required 1", bus.alu_ready);
    end
    push_wb(5'd7, 32'h77);
    tick();
    idle_inputs();
    bus.rs1_addr = 5'd0;
    tick();
    tick();
  endtask

  task automatic test_hazard();
    bus.rs1_addr = 5'd3; bus.rs2_addr = 5'd0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
    @(negedge clk);
    tests++;
    if (bus.issue_ready !== 1'b1 || bus.rs1_busy !== 1'b0) begin
      fails++;
      $display("FAIL hazard_issue: got issue_ready=%b rs1_busy=%b, required 1/0",
               bus.issue_ready, bus.rs1_busy);
    end
    tick();
    bus.issue_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b0) begin
        fails++;
        $display("FAIL hazard_pending%0d: got rs1_busy=%b rs2_busy=%b, required 1/0",
                 i, bus.rs1_busy, bus.rs2_busy);
      end
      tick();
    end
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h33;
    @(negedge clk);
    tests++;
    if (bus.lsu_ready !== 1'b1 || bus.rs1_busy !== 1'b1) begin
      fails++;
      $display("FAIL hazard_lsu_hs: got lsu_ready=%b rs1_busy=%b, required 1/1",
               bus.lsu_ready, bus.rs1_busy);
    end
    push_wb(5'd3, 32'h33);
    tick();
    bus.lsu_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b0) begin
      fails++;
      $display("FAIL hazard_commit: got rs1_busy=%b rs2_busy=%b, required 1/0",
               bus.rs1_busy, bus.rs2_busy);
    end
    tick();
    @(negedge clk);
    tests++;
    if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
      fails++;
      $display("FAIL hazard_clear: got rs1_busy=%b rs2_busy=%b, required 0/0",
               bus.rs1_busy, bus.rs2_busy);
    end
    tick();
    bus.rs1_addr = 5'd0;
  endtask

  task automatic test_x0();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hDEADBEEF;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
    @(negedge clk);
    tests++;
    if (bus.alu_ready !== 1'b1 || bus.issue_ready !== 1'b1) begin
      fails++;
      $display("FAIL x0_accept: got alu_ready=%b issue_ready=%b, required 1/1",
               bus.alu_ready, bus.issue_ready);
    end
    tick();
    bus.alu_valid = 1'b0;
    tests++;
    if (bus.rd_we !== 1'b0) begin
      fails++;
      $display("FAIL x0_no_write: got rd_we=%b, required 0", bus.rd_we);
    end
    @(negedge clk);
    tests++;
    if (bus.issue_ready !== 1'b1) begin
      fails++;
      $display("FAIL x0_reissue: got issue_ready=%b, required 1", bus.issue_ready);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reissue_and_reset();
    bus.rs1_addr = 5'd9; bus.rs2_addr = 5'd12;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    @(negedge clk);
    tests++;
    if (bus.issue_ready !== 1'b1) begin
      fails++;
      $display("FAIL reissue_first: got issue_ready=%b, required 1", bus.issue_ready);
    end
    tick();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h99;
    @(negedge clk);
    tests++;
    if (bus.lsu_ready !== 1'b1 || bus.issue_ready !== 1'b0) begin
      fails++;
      $display("FAIL reissue_same_cycle: got lsu_ready=%b issue_ready=%b, required 1/0",
               bus.lsu_ready, bus.issue_ready);
    end
    push_wb(5'd9, 32'h99);
    tick();
    bus.lsu_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.issue_ready !== 1'b1) begin
      fails++;
      $display("FAIL reissue_next: got issue_ready=%b, required 1", bus.issue_ready);
    end
    tick();
    bus.issue_rd = 5'd12;
    @(negedge clk);
    tests++;
    if (bus.issue_ready !== 1'b1 || bus.rs1_busy !== 1'b1) begin
      fails++;
      $display("FAIL reissue_sb9: got issue_ready=%b rs1_busy=%b, required 1/1",
               bus.issue_ready, bus.rs1_busy);
    end
    tick();
    bus.issue_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b1) begin
      fails++;
      $display("FAIL midflight_busy: got rs1_busy=%b rs2_busy=%b, required 1/1",
               bus.rs1_busy, bus.rs2_busy);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.issue_rd = 5'd9;
    @(negedge clk);
    tests++;
    if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0 || bus.issue_ready !== 1'b1) begin
      fails++;
      $display("FAIL midflight_reset: got rs1_busy=%b rs2_busy=%b issue_ready=%b, required 0/0/1",
               bus.rs1_busy, bus.rs2_busy, bus.issue_ready);
    end
    tick();
    bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.rs1_addr = 5'd0;
    bus.rs2_addr = 5'd0;
    test_reset();
    test_contention();
    test_waw_block();
    test_hazard();
    test_x0();
    test_reissue_and_reset();
    tick();
    tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL wb_leftover: got %0d pending writes, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
